// File: rtl/data_arb_pkg.sv
// Shared types and constants for the two-master RAM data-port arbiter.
// Defines the master identifier that is carried through the owner FIFO,
// the fixed master numbering, and a helper that returns the other master.
package data_arb_pkg;

    // One bit is enough to name either of the two masters.
    typedef logic master_id_t;

    localparam master_id_t MASTER_CORE = 1'b0;  // core data interface
    localparam master_id_t MASTER_DBG  = 1'b1;  // debug / host loader

    // The master that should get priority after the given one was served.
    function automatic master_id_t other_master(input master_id_t id);
        return (id == MASTER_CORE) ? MASTER_DBG : MASTER_CORE;
    endfunction

endpackage

// File: rtl/arb_owner_fifo.sv
// In-order owner FIFO: remembers which master issued each accepted request
// so returning responses can be steered back in issue order.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   push, push_id      enqueue the issuing master (ignored when full unless popping)
//   pop                dequeue the head (ignored when empty)
//   pop_id             master ID at the head
//   full, empty        occupancy flags
//   count              current number of entries
module arb_owner_fifo
    import data_arb_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  master_id_t       push_id,
    input  logic             pop,
    output master_id_t       pop_id,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    master_id_t       mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Advance a pointer with wrap-around at DEPTH (depth need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // A pop frees its slot in the same cycle, so a push is legal when full if it pairs with a pop.
    always_comb begin
        do_pop_s  = pop & ~empty;
        do_push_s = push & (~full | do_pop_s);
    end

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r    <= '{default: MASTER_CORE};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_id;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign pop_id = mem_r[rd_ptr_r];
    assign full   = (count_r == CNT_W'(DEPTH));
    assign empty  = (count_r == {CNT_W{1'b0}});
    assign count  = count_r;

endmodule

// File: rtl/data_port_arbiter.sv
// Two-master, one-slave arbiter for the RAM data port (req/gnt/rvalid,
// single beat, in-order responses). Master 0 is the core, master 1 the
// debug/host loader. Address phase is round-robin arbitrated with a
// zero-cycle grant path; responses are routed back through an owner FIFO.
// Ports:
//   clk_i, rstn_i              clock, asynchronous active-low reset
//   m0_* / m1_*                master request, address phase and response
//   s_*                        slave request, address phase and response
//   outstanding_o              issued-but-unanswered transaction count
//   spurious_rvalid_o          sticky: slave responded with nothing outstanding
module data_port_arbiter
    import data_arb_pkg::*;
#(
    parameter  int ADDR_WIDTH      = 22,
    parameter  int DATA_WIDTH      = 32,
    parameter  int MAX_OUTSTANDING = 2,
    localparam int BE_WIDTH        = DATA_WIDTH / 8,
    localparam int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  m0_req_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic                  m0_we_i,
    input  logic [BE_WIDTH-1:0]   m0_be_i,
    input  logic [DATA_WIDTH-1:0] m0_wdata_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,
    input  logic                  m1_req_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic                  m1_we_i,
    input  logic [BE_WIDTH-1:0]   m1_be_i,
    input  logic [DATA_WIDTH-1:0] m1_wdata_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,
    output logic                  s_req_o,
    output logic [ADDR_WIDTH-1:0] s_addr_o,
    output logic                  s_we_o,
    output logic [BE_WIDTH-1:0]   s_be_o,
    output logic [DATA_WIDTH-1:0] s_wdata_o,
    input  logic                  s_gnt_i,
    input  logic                  s_rvalid_i,
    input  logic [DATA_WIDTH-1:0] s_rdata_i,
    output logic [CNT_WIDTH-1:0]  outstanding_o,
    output logic                  spurious_rvalid_o
);

    logic       fifo_full_s;
    logic       fifo_empty_s;
    master_id_t head_id_s;
    logic       pop_s;
    logic       accept_s;
    logic       sel_valid_s;
    master_id_t sel_id_s;
    logic       push_s;
    master_id_t rr_ptr_r;
    logic       spurious_r;

    // Decide whether a new transaction may issue and which master owns the address phase.
    // Gating with rstn_i keeps every request/grant output low while reset is held.
    always_comb begin
        pop_s    = s_rvalid_i & ~fifo_empty_s;
        accept_s = rstn_i & (~fifo_full_s | pop_s);
        if (accept_s) begin
            case ({m1_req_i, m0_req_i})
                2'b11: begin
                    sel_valid_s = 1'b1;
                    sel_id_s    = rr_ptr_r;
                end
                2'b10: begin
                    sel_valid_s = 1'b1;
                    sel_id_s    = MASTER_DBG;
                end
                2'b01: begin
                    sel_valid_s = 1'b1;
                    sel_id_s    = MASTER_CORE;
                end
                default: begin
                    sel_valid_s = 1'b0;
                    sel_id_s    = MASTER_CORE;
                end
            endcase
        end else begin
            sel_valid_s = 1'b0;
            sel_id_s    = MASTER_CORE;
        end
    end

    // Address-phase mux and zero-cycle grant return; master 0 fields are the idle default.
    always_comb begin
        if (sel_valid_s && (sel_id_s == MASTER_DBG)) begin
            s_addr_o  = m1_addr_i;
            s_we_o    = m1_we_i;
            s_be_o    = m1_be_i;
            s_wdata_o = m1_wdata_i;
        end else begin
            s_addr_o  = m0_addr_i;
            s_we_o    = m0_we_i;
            s_be_o    = m0_be_i;
            s_wdata_o = m0_wdata_i;
        end
        s_req_o  = sel_valid_s;
        m0_gnt_o = sel_valid_s & (sel_id_s == MASTER_CORE) & s_gnt_i;
        m1_gnt_o = sel_valid_s & (sel_id_s == MASTER_DBG) & s_gnt_i;
        push_s   = sel_valid_s & s_gnt_i;
    end

    // Response steering: the FIFO head names the owner; rdata is broadcast to both.
    always_comb begin
        m0_rvalid_o = pop_s & (head_id_s == MASTER_CORE);
        m1_rvalid_o = pop_s & (head_id_s == MASTER_DBG);
        m0_rdata_o  = s_rdata_i;
        m1_rdata_o  = s_rdata_i;
    end

    // Round-robin pointer moves only on a completed handshake; spurious flag is sticky.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rr_ptr_r   <= MASTER_CORE;
            spurious_r <= 1'b0;
        end else begin
            if (push_s) begin
                rr_ptr_r <= other_master(sel_id_s);
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
            if (s_rvalid_i && fifo_empty_s) begin
                spurious_r <= 1'b1;
            end else begin
                spurious_r <= spurious_r;
            end
        end
    end

    arb_owner_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk     (clk_i),
        .rst_n   (rstn_i),
        .push    (push_s),
        .push_id (sel_id_s),
        .pop     (pop_s),
        .pop_id  (head_id_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (outstanding_o)
    );

    assign spurious_rvalid_o = spurious_r;

endmodule

// File: tb/tb_data_port_arbiter.sv
// Scoreboard bench for data_port_arbiter: a reference model tracks the
// outstanding-owner list and round-robin preference as plain queues/ints,
// the stimulus process checks the address phase every cycle and pushes
// expected responses; a separate monitor pops them when rvalid appears.
module tb_data_port_arbiter;

    localparam int AW   = 22;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int MAXO = 2;
    localparam int CW   = $clog2(MAXO + 1);

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic          m0_req_i, m1_req_i;
    logic [AW-1:0] m0_addr_i, m1_addr_i;
    logic          m0_we_i, m1_we_i;
    logic [BW-1:0] m0_be_i, m1_be_i;
    logic [DW-1:0] m0_wdata_i, m1_wdata_i;
    logic          m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
    logic [DW-1:0] m0_rdata_o, m1_rdata_o;
    logic          s_req_o, s_we_o, s_gnt_i, s_rvalid_i;
    logic [AW-1:0] s_addr_o;
    logic [BW-1:0] s_be_o;
    logic [DW-1:0] s_wdata_o, s_rdata_i;
    logic [CW-1:0] outstanding_o;
    logic          spurious_rvalid_o;

    data_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
        .m0_wdata_i(m0_wdata_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
        .m1_wdata_i(m1_wdata_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_be_o(s_be_o), .s_wdata_o(s_wdata_o),
        .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
        .outstanding_o(outstanding_o), .spurious_rvalid_o(spurious_rvalid_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
    } exp_t;

    int            vectors     = 0;
    int            miscompares = 0;
    exp_t          exp_q[$];     // scoreboard: expected responses in order
    int            own_q[$];     // model: issuing master of each outstanding transaction
    logic [DW-1:0] slave_q[$];   // slave memory model: read data owed, in order
    int            pref        = 0;
    bit            spur_m      = 1'b0;
    bit            g0_last     = 1'b0;
    bit            g1_last     = 1'b0;
    bit            r0r         = 1'b0;
    bit            r1r         = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // One clock: drive at negedge, check address phase 2 units later, update model at posedge.
    task automatic tick(input bit r0, input bit r1, input bit sg, input bit sv);
        int            cnt;
        int            sel;
        bit            pop;
        bit            acc;
        bit            hs_obs;
        logic [DW-1:0] obs_data;
        logic [AW-1:0] sel_addr;
        @(negedge clk_i);
        m0_req_i   = r0;
        m1_req_i   = r1;
        s_gnt_i    = sg;
        s_rvalid_i = sv;
        s_rdata_i  = (slave_q.size() > 0) ? slave_q[0] : DW'($urandom);
        #2;
        cnt = own_q.size();
        pop = sv && (cnt > 0);
        acc = (cnt < MAXO) || pop;
        sel = -1;
        if (acc) begin
            if (r0 && r1) sel = pref;
            else if (r0)  sel = 0;
            else if (r1)  sel = 1;
        end
        sel_addr = (sel == 1) ? m1_addr_i : m0_addr_i;
        check("s_req", s_req_o, sel >= 0);
        check("m0_gnt", m0_gnt_o, (sel == 0) && sg);
        check("m1_gnt", m1_gnt_o, (sel == 1) && sg);
        check("s_addr", s_addr_o, sel_addr);
        check("s_we", s_we_o, (sel == 1) ? m1_we_i : m0_we_i);
        check("s_be", s_be_o, (sel == 1) ? m1_be_i : m0_be_i);
        check("s_wdata", s_wdata_o, (sel == 1) ? m1_wdata_i : m0_wdata_i);
        check("rvalid_any", m0_rvalid_o | m1_rvalid_o, pop);
        check("outstanding", outstanding_o, cnt);
        check("spurious", spurious_rvalid_o, spur_m);
        g0_last = (sel == 0) && sg;
        g1_last = (sel == 1) && sg;
        if ((sel >= 0) && sg) exp_q.push_back('{sel, DW'(sel_addr)});
        hs_obs   = s_req_o & s_gnt_i;
        obs_data = DW'(s_addr_o);
        @(posedge clk_i);
        if (sv && (cnt == 0)) spur_m = 1'b1;
        if (pop) void'(own_q.pop_front());
        if ((sel >= 0) && sg) begin
            own_q.push_back(sel);
            pref = 1 - sel;
        end
        if (sv && (slave_q.size() > 0)) void'(slave_q.pop_front());
        if (hs_obs) slave_q.push_back(obs_data);
    endtask

    // Asynchronous reset in the middle of the high phase, with both masters requesting.
    task automatic apply_reset();
        m0_req_i   = 1'b1;
        m1_req_i   = 1'b1;
        s_gnt_i    = 1'b1;
        s_rvalid_i = 1'b0;
        #3;
        rstn_i = 1'b0;
        #1;
        check("rst_s_req", s_req_o, 1'b0);
        check("rst_m0_gnt", m0_gnt_o, 1'b0);
        check("rst_m1_gnt", m1_gnt_o, 1'b0);
        check("rst_m0_rvalid", m0_rvalid_o, 1'b0);
        check("rst_m1_rvalid", m1_rvalid_o, 1'b0);
        check("rst_outstanding", outstanding_o, 0);
        check("rst_spurious", spurious_rvalid_o, 1'b0);
        exp_q.delete();
        own_q.delete();
        slave_q.delete();
        pref     = 0;
        spur_m   = 1'b0;
        m0_req_i = 1'b0;
        m1_req_i = 1'b0;
        s_gnt_i  = 1'b0;
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * MAXO + 2; i++) tick(1'b0, 1'b0, 1'b0, slave_q.size() > 0);
    endtask

    // Monitor: whenever a master sees rvalid, pop the scoreboard and compare owner and data.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            #3;
            if (m0_rvalid_o && m1_rvalid_o) begin
                check("rvalid_both", {m1_rvalid_o, m0_rvalid_o}, 2'b00);
            end else if (m0_rvalid_o || m1_rvalid_o) begin
                if (exp_q.size() == 0) begin
                    check("rvalid_unexpected", {m1_rvalid_o, m0_rvalid_o}, 2'b00);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_owner", m1_rvalid_o ? 1 : 0, e.id);
                    check("resp_rdata", m1_rvalid_o ? m1_rdata_o : m0_rdata_o, e.data);
                end
            end
        end
    end

    initial begin
        rstn_i     = 1'b1;
        m0_addr_i  = 22'h000100; m1_addr_i  = 22'h000200;
        m0_we_i    = 1'b0;       m1_we_i    = 1'b0;
        m0_be_i    = 4'hF;       m1_be_i    = 4'hF;
        m0_wdata_i = 32'h0;      m1_wdata_i = 32'h0;
        s_rdata_i  = 32'h0;
        apply_reset();

        // Spurious rvalid with nothing outstanding sets a sticky flag.
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        apply_reset();

        // Continuous contention: grants alternate, responses one cycle after grant.
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 1'b1, slave_q.size() > 0);
        drain();

        // Fill the owner FIFO, then a response frees a slot in the same cycle.
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        drain();

        // Only m1 requests after an m0 grant: back-to-back grants, no idle cycles.
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b1, slave_q.size() > 0);
        drain();

        // Slave stall with write beats held, then exactly one grant.
        m0_we_i = 1'b1; m0_be_i = 4'b0101; m0_wdata_i = 32'hDEADBEEF; m0_addr_i = 22'h000340;
        m1_we_i = 1'b1; m1_be_i = 4'b1010; m1_wdata_i = 32'hCAFEF00D; m1_addr_i = 22'h000380;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        drain();

        // Reset with two transactions outstanding; contention afterwards goes to m0.
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        apply_reset();
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        drain();

        // Randomized traffic; a request is held with stable fields until granted.
        g0_last = 1'b1;
        g1_last = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if (!r0r || g0_last) begin
                r0r        = ($urandom_range(0, 3) != 0);
                m0_addr_i  = AW'($urandom);
                m0_we_i    = 1'($urandom);
                m0_be_i    = BW'($urandom);
                m0_wdata_i = DW'($urandom);
            end
            if (!r1r || g1_last) begin
                r1r        = ($urandom_range(0, 2) != 0);
                m1_addr_i  = AW'($urandom);
                m1_we_i    = 1'($urandom);
                m1_be_i    = BW'($urandom);
                m1_wdata_i = DW'($urandom);
            end
            tick(r0r, r1r, $urandom_range(0, 3) != 0,
                 (slave_q.size() > 0) && ($urandom_range(0, 1) == 1));
        end
        drain();
        check("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
